// File: rtl/system_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 30-bit frames of up to 15 atoms.
// Frames are handed off through a single holding register over valid/ready.
module system_nios2_qsys_oci_dct_packer #(
    parameter int unsigned ATOM_W = 2,
    parameter int unsigned ATOMS  = 15,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      trace_en,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom,
    output logic                      atom_ready,
    input  logic                      flush,
    output logic [ATOM_W*ATOMS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    output logic                      frame_valid,
    output logic [ATOM_W*ATOMS-1:0]   frame_data,
    output logic [CNT_W-1:0]          frame_count,
    input  logic                      frame_ready,
    output logic [15:0]               frames_sent
);

    localparam int unsigned BUF_W = ATOM_W * ATOMS;

    logic [BUF_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flush_pending;
    logic             r_frame_valid;
    logic [BUF_W-1:0] r_frame_data;
    logic [CNT_W-1:0] r_frame_count;
    logic [15:0]      r_frames_sent;

    logic             w_out_free;
    logic             w_cnt_full;
    logic             w_transfer;
    logic             w_accept;
    logic [BUF_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pend_nxt;

    assign w_out_free = !r_frame_valid || frame_ready;
    assign w_cnt_full = (r_cnt == CNT_W'(ATOMS));
    assign w_transfer = w_out_free && (r_cnt != '0) && (w_cnt_full || r_flush_pending);
    assign atom_ready = trace_en && (!w_cnt_full || w_transfer);
    assign w_accept   = atom_valid && atom_ready;

    // An atom arriving with a transfer lands in the freshly emptied accumulator.
    always_comb begin
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_cnt;
        if (w_transfer) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
        end
        if (w_accept) begin
            w_acc_nxt = {w_acc_nxt[BUF_W-ATOM_W-1:0], atom};
            w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
        end
        w_pend_nxt = (flush || (r_flush_pending && !w_transfer)) && (w_cnt_nxt != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc           <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_acc           <= w_acc_nxt;
            r_cnt           <= w_cnt_nxt;
            r_flush_pending <= w_pend_nxt;
        end
    end

    // Output holding register; contents stay put until consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_count <= '0;
            r_frames_sent <= '0;
        end else if (w_transfer) begin
            r_frame_valid <= 1'b1;
            r_frame_data  <= r_acc;
            r_frame_count <= r_cnt;
            r_frames_sent <= r_frames_sent + 16'd1;
        end else if (r_frame_valid && frame_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

    assign dct_buffer  = r_acc;
    assign dct_count   = r_cnt;
    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
    assign frame_count = r_frame_count;
    assign frames_sent = r_frames_sent;

endmodule
